collision_unit: RTL and testbench
=================================

COLLISION_UNIT -- requirements
Module: collision_unit

Interface
REQ-001 SHALL provide parameter LIVES, default 3, lives loaded at game start (range 1..15).
REQ-002 SHALL provide parameter COOLDOWN_FRAMES, default 30, frames of hit immunity after a hit (range 1..255).
REQ-003 SHALL provide parameter SLOW_FRAMES, default 60, frames slow_down stays high after a hit (range 1..255).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port resetN  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port startOfFrame  input  1  one-cycle pulse at start of each VGA frame.
REQ-007 SHALL have port start  input  1  one-cycle game-start request.
REQ-008 SHALL have port drawing_bird  input  1  bird covers current pixel.
REQ-009 SHALL have ports drawing_building_1 / drawing_building_2  input  1 each  building k covers current pixel.
REQ-010 SHALL have ports destructed_building_1 / destructed_building_2  input  1 each  building k already destroyed.
REQ-011 SHALL have ports collision_building_1 / collision_building_2  output  1 each  one-cycle hit pulse to the buildings unit.
REQ-012 SHALL have port slow_down  output  1  request to buildings unit to slow scrolling.
REQ-013 SHALL have port lives  output  4  remaining lives.
REQ-014 SHALL have port game_over  output  1  high in OVER state.

Function
REQ-015 SHALL implement states IDLE, PLAY, COOLDOWN, OVER; encoding free.
REQ-016 SHALL set sticky flag hit_k on any cycle with drawing_bird & drawing_building_k & !destructed_building_k; flags accumulate over one frame.
REQ-017 SHALL evaluate and clear both flags on each startOfFrame cycle; a hit on that same cycle SHALL be recorded into the new frame.
REQ-018 In PLAY, SHALL pulse collision_building_k for exactly one cycle, the cycle after startOfFrame, for each set hit_k (both may pulse together).
REQ-019 Any frame with >=1 hit SHALL decrement lives by exactly 1 (two buildings = one life), saturating at 0.
REQ-020 After a hit with lives>0 remaining, SHALL go PLAY->COOLDOWN; after COOLDOWN_FRAMES startOfFrame pulses SHALL return to PLAY.
REQ-021 In COOLDOWN, IDLE and OVER, flags SHALL be cleared at startOfFrame with no collision pulse and no lives change.
REQ-022 When lives reaches 0, SHALL enter OVER on the same cycle as the decrement; game_over=1 until start or reset.
REQ-023 start in IDLE or OVER SHALL load lives=LIVES, clear flags and counters, enter PLAY next cycle; start in PLAY/COOLDOWN SHALL be ignored.
REQ-024 start coincident with startOfFrame SHALL take priority; that frame's flags discarded.
REQ-025 slow_down SHALL rise the cycle after a counted hit and stay high for SLOW_FRAMES startOfFrame pulses; a new hit reloads the counter; forced low in IDLE/OVER.
REQ-026 Frame counters SHALL be 8-bit, unsigned, no wrap (hold at 0).

Reset
REQ-027 On resetN=0, asynchronously: state=IDLE, lives=0, flags=0, counters=0, all outputs 0.
REQ-028 Reset mid-frame or mid-COOLDOWN SHALL discard pending hits; no pulse after release until a start.

Configuration
REQ-029 SHALL support macro COLLISION_GROUND_EN: when defined, adds input drawing_ground (1 bit); drawing_bird & drawing_ground in PLAY or COOLDOWN forces lives=0 and OVER at the next startOfFrame, with no building pulse.
REQ-030 Without COLLISION_GROUND_EN, drawing_ground port SHALL be absent and ground contact SHALL have no effect.

Verification
REQ-031 start, then overlap bird+building_1 for 5 pixels in frame N -> single collision_building_1 pulse cycle after startOfFrame N+1, lives 3->2, slow_down high 60 frames.
REQ-032 Overlap with both buildings in one frame -> both pulses same cycle, lives decrements by 1 only.
REQ-033 Hit again 10 frames after first hit (COOLDOWN) -> no pulse, lives unchanged; hit at frame 31 -> pulse, lives decrements.
REQ-034 Three counted hits from LIVES=3 -> lives=0, game_over=1; further overlaps ignored; start -> lives=3, PLAY.
REQ-035 Overlap with destructed_building_2=1 -> no flag, no pulse; resetN low mid-frame with flag set -> no pulse after release.
REQ-036 With COLLISION_GROUND_EN, bird+ground contact in PLAY -> game_over=1 at next startOfFrame, lives=0.

Source files
------------

// File: rtl/collision_unit.sv
// collision_unit: bird/building collision bookkeeping for the flappy game.
// Accumulates per-frame hit flags, emits one-cycle hit pulses to the
// buildings unit, tracks lives, hit immunity (COOLDOWN) and slow-down time.
// Optional feature: define COLLISION_GROUND_EN to add the drawing_ground
// input; ground contact in PLAY/COOLDOWN ends the game at the next frame.
module collision_unit #(
    parameter int LIVES           = 3,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int SLOW_FRAMES     = 60
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       start,
    input  logic       drawing_bird,
    input  logic       drawing_building_1,
    input  logic       drawing_building_2,
    input  logic       destructed_building_1,
    input  logic       destructed_building_2,
`ifdef COLLISION_GROUND_EN
    input  logic       drawing_ground,
`endif
    output logic       collision_building_1,
    output logic       collision_building_2,
    output logic       slow_down,
    output logic [3:0] lives,
    output logic       game_over
);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        COOLDOWN,
        OVER
    } state_t;

    localparam logic [3:0] LIVES_INIT = 4'(LIVES);
    localparam logic [7:0] COOL_INIT  = 8'(COOLDOWN_FRAMES);
    localparam logic [7:0] SLOW_INIT  = 8'(SLOW_FRAMES);

    state_t     state_q, state_d;
    logic [3:0] lives_q, lives_d;
    logic       hit1_q, hit1_d;
    logic       hit2_q, hit2_d;
    logic       ground_q, ground_d;
    logic [7:0] cool_cnt_q, cool_cnt_d;
    logic [7:0] slow_cnt_q, slow_cnt_d;
    logic       coll1_q, coll1_d;
    logic       coll2_q, coll2_d;

    logic       hit1_now;
    logic       hit2_now;
    logic       ground_now;
    logic       active;
    logic [3:0] lives_dec;

    // Per-pixel contact detection for the current cycle
    always_comb begin
        active   = (state_q == PLAY) || (state_q == COOLDOWN);
        hit1_now = drawing_bird & drawing_building_1 & ~destructed_building_1;
        hit2_now = drawing_bird & drawing_building_2 & ~destructed_building_2;
`ifdef COLLISION_GROUND_EN
        ground_now = drawing_bird & drawing_ground & active;
`else
        ground_now = 1'b0;
`endif
        lives_dec = (lives_q == 4'd0) ? 4'd0 : lives_q - 4'd1;
    end

    // Next-state, flag, counter and pulse logic
    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        hit1_d     = hit1_q | hit1_now;
        hit2_d     = hit2_q | hit2_now;
        ground_d   = ground_q | ground_now;
        cool_cnt_d = cool_cnt_q;
        slow_cnt_d = slow_cnt_q;
        coll1_d    = 1'b0;
        coll2_d    = 1'b0;

        if (start && ((state_q == IDLE) || (state_q == OVER))) begin
            // A game start wins over a coincident frame boundary; the
            // frame being closed is simply discarded.
            state_d    = PLAY;
            lives_d    = LIVES_INIT;
            hit1_d     = 1'b0;
            hit2_d     = 1'b0;
            ground_d   = 1'b0;
            cool_cnt_d = '0;
            slow_cnt_d = '0;
        end else if (startOfFrame) begin
            // Close the old frame; contact on this cycle opens the new one.
            hit1_d   = hit1_now;
            hit2_d   = hit2_now;
            ground_d = ground_now;
            if (slow_cnt_q != 8'd0) begin
                slow_cnt_d = slow_cnt_q - 8'd1;
            end

            case (state_q)
                PLAY: begin
                    if (ground_q) begin
                        lives_d    = '0;
                        state_d    = OVER;
                        slow_cnt_d = '0;
                    end else if (hit1_q || hit2_q) begin
                        coll1_d = hit1_q;
                        coll2_d = hit2_q;
                        lives_d = lives_dec;
                        if (lives_dec == 4'd0) begin
                            state_d    = OVER;
                            slow_cnt_d = '0;
                        end else begin
                            state_d    = COOLDOWN;
                            cool_cnt_d = COOL_INIT;
                            slow_cnt_d = SLOW_INIT;
                        end
                    end
                end
                COOLDOWN: begin
                    if (ground_q) begin
                        lives_d    = '0;
                        state_d    = OVER;
                        slow_cnt_d = '0;
                        cool_cnt_d = '0;
                    end else if (cool_cnt_q <= 8'd1) begin
                        cool_cnt_d = '0;
                        state_d    = PLAY;
                    end else begin
                        cool_cnt_d = cool_cnt_q - 8'd1;
                    end
                end
                default: begin
                    slow_cnt_d = '0;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            lives_q    <= '0;
            hit1_q     <= 1'b0;
            hit2_q     <= 1'b0;
            ground_q   <= 1'b0;
            cool_cnt_q <= '0;
            slow_cnt_q <= '0;
            coll1_q    <= 1'b0;
            coll2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            hit1_q     <= hit1_d;
            hit2_q     <= hit2_d;
            ground_q   <= ground_d;
            cool_cnt_q <= cool_cnt_d;
            slow_cnt_q <= slow_cnt_d;
            coll1_q    <= coll1_d;
            coll2_q    <= coll2_d;
        end
    end

    // Output decode
    always_comb begin
        collision_building_1 = coll1_q;
        collision_building_2 = coll2_q;
        lives                = lives_q;
        game_over            = (state_q == OVER);
        slow_down            = (slow_cnt_q != 8'd0) && active;
    end

endmodule

// File: tb/tb_collision_unit.sv
// Scoreboard bench for collision_unit: expected hit pulses are queued when a
// frame is closed and checked by an independent monitor on the falling edge.
module tb_collision_unit;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       start = 1'b0;
    logic       drawing_bird = 1'b0;
    logic       drawing_building_1 = 1'b0;
    logic       drawing_building_2 = 1'b0;
    logic       destructed_building_1 = 1'b0;
    logic       destructed_building_2 = 1'b0;
`ifdef COLLISION_GROUND_EN
    logic       drawing_ground = 1'b0;
`endif
    logic       collision_building_1;
    logic       collision_building_2;
    logic       slow_down;
    logic [3:0] lives;
    logic       game_over;

    int tests = 0;
    int fails = 0;

    // {coll1, coll2, lives[3:0], slow_down, game_over}
    logic [7:0] exp_q[$];

    collision_unit #(.LIVES(3), .COOLDOWN_FRAMES(30), .SLOW_FRAMES(60)) dut (
        .clk                   (clk),
        .resetN                (resetN),
        .startOfFrame          (startOfFrame),
        .start                 (start),
        .drawing_bird          (drawing_bird),
        .drawing_building_1    (drawing_building_1),
        .drawing_building_2    (drawing_building_2),
        .destructed_building_1 (destructed_building_1),
        .destructed_building_2 (destructed_building_2),
`ifdef COLLISION_GROUND_EN
        .drawing_ground        (drawing_ground),
`endif
        .collision_building_1  (collision_building_1),
        .collision_building_2  (collision_building_2),
        .slow_down             (slow_down),
        .lives                 (lives),
        .game_over             (game_over)
    );

    always #5 clk = ~clk;

    // Monitor: every hit pulse must match the oldest queued expectation
    always @(negedge clk) begin
        logic [7:0] got;
        logic [7:0] e;
        if (collision_building_1 || collision_building_2) begin
            got = {collision_building_1, collision_building_2, lives, slow_down, game_over};
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pulse_unexpected got=%b required=none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    fails++;
                    $display("FAIL pulse got=%b required=%b", got, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic ov(input logic b1, input logic b2, input logic d1, input logic d2, input int n);
        drawing_bird          = 1'b1;
        drawing_building_1    = b1;
        drawing_building_2    = b2;
        destructed_building_1 = d1;
        destructed_building_2 = d2;
        repeat (n) tick();
        drawing_bird          = 1'b0;
        drawing_building_1    = 1'b0;
        drawing_building_2    = 1'b0;
        destructed_building_1 = 1'b0;
        destructed_building_2 = 1'b0;
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic push(input logic c1, input logic c2, input logic [3:0] l,
                        input logic s, input logic g);
        exp_q.push_back({c1, c2, l, s, g});
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s got=%0d required=%0d", name, act, req);
        end
    endtask

    initial begin
        // Reset state
        idle(3);
        check("rst_lives", {4'd0, lives}, 8'd0);
        check("rst_game_over", {7'd0, game_over}, 8'd0);
        check("rst_slow", {7'd0, slow_down}, 8'd0);
        check("rst_coll", {6'd0, collision_building_1, collision_building_2}, 8'd0);
        resetN = 1'b1;
        idle(2);

        // Game start
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_lives", {4'd0, lives}, 8'd3);
        check("start_game_over", {7'd0, game_over}, 8'd0);

        // First hit: frame with 5 overlapping pixels, closed by S1
        ov(1'b1, 1'b0, 1'b0, 1'b0, 5);
        idle(2);
        push(1'b1, 1'b0, 4'd2, 1'b1, 1'b0);
        sof();
        idle(1);

        for (int s = 2; s <= 94; s++) begin
            if (s == 11 || s == 31 || s == 94) ov(1'b1, 1'b0, 1'b0, 1'b0, 5);
            if (s == 32) ov(1'b1, 1'b1, 1'b0, 1'b0, 5);
            if (s == 93) ov(1'b0, 1'b1, 1'b0, 1'b1, 5);
            if (s == 15) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                check("start_ignored_cooldown", {4'd0, lives}, 8'd2);
            end
            idle(2);
            if (s == 32) push(1'b1, 1'b1, 4'd1, 1'b1, 1'b0);
            if (s == 94) push(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
            sof();
            if (s == 2)  check("slow_after_hit", {7'd0, slow_down}, 8'd1);
            if (s == 11) check("cooldown_hit_lives", {4'd0, lives}, 8'd2);
            if (s == 31) check("cooldown_edge_lives", {4'd0, lives}, 8'd2);
            if (s == 91) check("slow_last_frame", {7'd0, slow_down}, 8'd1);
            if (s == 92) check("slow_expired", {7'd0, slow_down}, 8'd0);
            if (s == 93) check("destructed_lives", {4'd0, lives}, 8'd1);
            if (s == 94) begin
                check("over_lives", {4'd0, lives}, 8'd0);
                check("over_flag", {7'd0, game_over}, 8'd1);
            end
            idle(1);
        end

        // Overlap in OVER is ignored
        ov(1'b1, 1'b0, 1'b0, 1'b0, 5);
        sof();
        idle(2);
        check("over_ignore_lives", {4'd0, lives}, 8'd0);

        // Start coincident with startOfFrame, pending flags discarded
        ov(1'b1, 1'b0, 1'b0, 1'b0, 5);
        startOfFrame = 1'b1;
        start = 1'b1;
        tick();
        startOfFrame = 1'b0;
        start = 1'b0;
        check("restart_lives", {4'd0, lives}, 8'd3);
        check("restart_game_over", {7'd0, game_over}, 8'd0);
        idle(3);
        sof();
        idle(2);
        check("restart_no_hit_lives", {4'd0, lives}, 8'd3);

        // Contact on the startOfFrame cycle belongs to the new frame
        drawing_bird = 1'b1;
        drawing_building_1 = 1'b1;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        drawing_bird = 1'b0;
        drawing_building_1 = 1'b0;
        check("sof_same_cycle_lives", {4'd0, lives}, 8'd3);
        idle(3);
        push(1'b1, 1'b0, 4'd2, 1'b1, 1'b0);
        sof();
        idle(2);

        // Reset mid-frame with a pending flag
        idle(2);
        ov(1'b1, 1'b0, 1'b0, 1'b0, 3);
        resetN = 1'b0;
        idle(2);
        check("midreset_lives", {4'd0, lives}, 8'd0);
        check("midreset_slow", {7'd0, slow_down}, 8'd0);
        resetN = 1'b1;
        idle(2);
        sof();
        idle(3);
        sof();
        idle(2);
        check("postreset_lives", {4'd0, lives}, 8'd0);

`ifdef COLLISION_GROUND_EN
        // Ground contact ends the game at the next frame boundary
        start = 1'b1;
        tick();
        start = 1'b0;
        drawing_bird = 1'b1;
        drawing_ground = 1'b1;
        idle(3);
        drawing_bird = 1'b0;
        drawing_ground = 1'b0;
        check("ground_before_sof", {7'd0, game_over}, 8'd0);
        sof();
        check("ground_game_over", {7'd0, game_over}, 8'd1);
        check("ground_lives", {4'd0, lives}, 8'd0);
        idle(2);
`endif

        idle(5);
        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
